// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the memory bus arbiter.
// Also used by the CPU top level for its memory pointer/data widths.
package mem_arb_pkg;

   localparam int unsigned ARB_ADDR_W = 16;
   localparam int unsigned ARB_DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADDR = 2'd1,
      DATA = 2'd2,
      RESP = 2'd3
   } arb_state_t;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_DBG = 1'b1
   } arb_owner_t;

   // Width of a down-counter that must hold n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner select between the CPU and debug requesters.
// MEM_BUS_ARBITER_RR_EN selects round-robin on ties; otherwise the CPU wins ties.
module mem_arb_pick
   import mem_arb_pkg::*;
(
   input  logic       cpu_req,
   input  logic       dbg_req,
   input  arb_owner_t last_owner,
   output logic       grant_valid_c,
   output arb_owner_t grant_owner_c
);

   assign grant_valid_c = cpu_req | dbg_req;

`ifdef MEM_BUS_ARBITER_RR_EN
   // On a tie the requester that did not own the previous grant wins.
   always_comb begin
      grant_owner_c = OWNER_CPU;
      if (cpu_req && dbg_req) begin
         grant_owner_c = (last_owner == OWNER_CPU) ? OWNER_DBG : OWNER_CPU;
      end else if (dbg_req) begin
         grant_owner_c = OWNER_DBG;
      end
   end
`else
   logic unused_last_owner;
   assign unused_last_owner = ^last_owner;

   always_comb begin
      grant_owner_c = OWNER_CPU;
      if (!cpu_req && dbg_req) begin
         grant_owner_c = OWNER_DBG;
      end
   end
`endif

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory port between the CPU FSM and the debug/loader port.
// Optional round-robin arbitration via MEM_BUS_ARBITER_RR_EN.
module mem_bus_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W      = ARB_ADDR_W,
   parameter int unsigned DATA_W      = ARB_DATA_W,
   parameter int unsigned WAIT_CYCLES = 1
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ack,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ack,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_addr_valid,
   output logic              mem_en,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam int unsigned CNT_W = cnt_width(WAIT_CYCLES);

   arb_state_t       state;
   arb_owner_t       owner;
   arb_owner_t       last_owner;
   logic             lat_we;
   logic [CNT_W-1:0] wait_cnt;
   logic             grant_valid_c;
   arb_owner_t       grant_owner_c;

   mem_arb_pick u_pick (
      .cpu_req       (cpu_req),
      .dbg_req       (dbg_req),
      .last_owner    (last_owner),
      .grant_valid_c (grant_valid_c),
      .grant_owner_c (grant_owner_c)
   );

`ifdef MEM_BUS_ARBITER_RR_EN
   // Resets to DBG so the CPU wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= OWNER_DBG;
      end else if (state == IDLE && grant_valid_c) begin
         last_owner <= grant_owner_c;
      end
   end
`else
   assign last_owner = OWNER_DBG;
`endif

   // Transaction sequencer: address phase, data phase(s), response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         owner          <= OWNER_CPU;
         lat_we         <= 1'b0;
         wait_cnt       <= '0;
         cpu_ack        <= 1'b0;
         dbg_ack        <= 1'b0;
         cpu_rdata      <= '0;
         dbg_rdata      <= '0;
         mem_addr       <= '0;
         mem_addr_valid <= 1'b0;
         mem_en         <= 1'b0;
         mem_we         <= 1'b0;
         mem_wdata      <= '0;
         busy           <= 1'b0;
      end else begin
         cpu_ack        <= 1'b0;
         dbg_ack        <= 1'b0;
         mem_addr_valid <= 1'b0;
         mem_en         <= 1'b0;
         mem_we         <= 1'b0;

         case (state)
            IDLE: begin
               if (grant_valid_c) begin
                  owner <= grant_owner_c;
                  if (grant_owner_c == OWNER_CPU) begin
                     lat_we    <= cpu_we;
                     mem_addr  <= cpu_addr;
                     mem_wdata <= cpu_wdata;
                  end else begin
                     lat_we    <= dbg_we;
                     mem_addr  <= dbg_addr;
                     mem_wdata <= dbg_wdata;
                  end
                  mem_addr_valid <= 1'b1;
                  busy           <= 1'b1;
                  state          <= ADDR;
               end
            end

            ADDR: begin
               wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
               mem_en   <= 1'b1;
               mem_we   <= lat_we;
               state    <= DATA;
            end

            DATA: begin
               if (wait_cnt != '0) begin
                  wait_cnt <= wait_cnt - CNT_W'(1);
                  mem_en   <= 1'b1;
                  mem_we   <= lat_we;
               end else begin
                  // Read data is valid on the last data-phase cycle.
                  if (owner == OWNER_CPU) begin
                     cpu_ack <= 1'b1;
                     if (!lat_we) cpu_rdata <= mem_rdata;
                  end else begin
                     dbg_ack <= 1'b1;
                     if (!lat_we) dbg_rdata <= mem_rdata;
                  end
                  state <= RESP;
               end
            end

            RESP: begin
               busy  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: WAIT_CYCLES=1 instance plus a WAIT_CYCLES=3 instance.
// Expected arbitration order follows MEM_BUS_ARBITER_RR_EN.
module tb_mem_bus_arbiter;

   logic        clk;
   logic        rst_n;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [15:0] cpu_addr, dbg_addr;
   logic [7:0]  cpu_wdata, dbg_wdata, mem_rdata;

   logic        cpu_ack, dbg_ack, mem_addr_valid, mem_en, mem_we, busy;
   logic [7:0]  cpu_rdata, dbg_rdata, mem_wdata;
   logic [15:0] mem_addr;

   logic        cpu_ack3, dbg_ack3, mem_addr_valid3, mem_en3, mem_we3, busy3;
   logic [7:0]  cpu_rdata3, dbg_rdata3, mem_wdata3;
   logic [15:0] mem_addr3;

   int n_checks = 0;
   int n_fail   = 0;

   mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_addr(mem_addr), .mem_addr_valid(mem_addr_valid), .mem_en(mem_en),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   mem_bus_arbiter #(.ADDR_W(16), .DATA_W(8), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(cpu_ack3), .cpu_rdata(cpu_rdata3),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack3), .dbg_rdata(dbg_rdata3),
      .mem_addr(mem_addr3), .mem_addr_valid(mem_addr_valid3), .mem_en(mem_en3),
      .mem_we(mem_we3), .mem_wdata(mem_wdata3), .mem_rdata(mem_rdata), .busy(busy3)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req   = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      mem_rdata = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic exp_cpu [4];

   initial begin
      // Reset state
      do_reset();
      chk("rst_busy", 32'(busy), 0);
      chk("rst_cpu_ack", 32'(cpu_ack), 0);
      chk("rst_dbg_ack", 32'(dbg_ack), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_we", 32'(mem_we), 0);
      chk("rst_mav", 32'(mem_addr_valid), 0);
      chk("rst_mem_addr", 32'(mem_addr), 0);
      chk("rst_mem_wdata", 32'(mem_wdata), 0);
      chk("rst_cpu_rdata", 32'(cpu_rdata), 0);
      chk("rst_dbg_rdata", 32'(dbg_rdata), 0);

      // CPU read, WAIT_CYCLES=1
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; mem_rdata = 8'h5A;
      tick();
      chk("rd_c1_mav", 32'(mem_addr_valid), 1);
      chk("rd_c1_addr", 32'(mem_addr), 32'h0010);
      chk("rd_c1_en", 32'(mem_en), 0);
      chk("rd_c1_busy", 32'(busy), 1);
      tick();
      chk("rd_c2_en", 32'(mem_en), 1);
      chk("rd_c2_we", 32'(mem_we), 0);
      chk("rd_c2_mav", 32'(mem_addr_valid), 0);
      chk("rd_c2_ack", 32'(cpu_ack), 0);
      tick();
      chk("rd_c3_ack", 32'(cpu_ack), 1);
      chk("rd_c3_rdata", 32'(cpu_rdata), 32'h5A);
      chk("rd_c3_dbg_ack", 32'(dbg_ack), 0);
      chk("rd_c3_en", 32'(mem_en), 0);
      cpu_req = 1'b0;
      tick();
      chk("rd_c4_ack", 32'(cpu_ack), 0);
      chk("rd_c4_busy", 32'(busy), 0);
      chk("rd_c4_rdata_hold", 32'(cpu_rdata), 32'h5A);

      // Debug write on the WAIT_CYCLES=3 instance
      do_reset();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h1234; dbg_wdata = 8'hA5; mem_rdata = 8'h77;
      tick();
      chk("dw_c1_mav", 32'(mem_addr_valid3), 1);
      chk("dw_c1_addr", 32'(mem_addr3), 32'h1234);
      chk("dw_c1_en", 32'(mem_en3), 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("dw_data_en", 32'(mem_en3), 1);
         chk("dw_data_we", 32'(mem_we3), 1);
         chk("dw_data_wdata", 32'(mem_wdata3), 32'hA5);
         chk("dw_data_ack", 32'(dbg_ack3), 0);
      end
      tick();
      chk("dw_c5_ack", 32'(dbg_ack3), 1);
      chk("dw_c5_cpu_ack", 32'(cpu_ack3), 0);
      chk("dw_c5_we", 32'(mem_we3), 0);
      chk("dw_c5_en", 32'(mem_en3), 0);
      chk("dw_c5_rdata", 32'(dbg_rdata3), 0);
      dbg_req = 1'b0;
      tick();
      chk("dw_c6_ack", 32'(dbg_ack3), 0);
      chk("dw_c6_busy", 32'(busy3), 0);
      chk("dw_c6_wdata_hold", 32'(mem_wdata3), 32'hA5);

      // Both requesting continuously, four transactions
`ifdef MEM_BUS_ARBITER_RR_EN
      exp_cpu[0] = 1'b1; exp_cpu[1] = 1'b0; exp_cpu[2] = 1'b1; exp_cpu[3] = 1'b0;
`else
      exp_cpu[0] = 1'b1; exp_cpu[1] = 1'b1; exp_cpu[2] = 1'b1; exp_cpu[3] = 1'b1;
`endif
      do_reset();
      cpu_req = 1'b1; dbg_req = 1'b1; cpu_addr = 16'h0001; dbg_addr = 16'h0002; mem_rdata = 8'h11;
      for (int k = 0; k < 4; k++) begin
         repeat ((k == 0) ? 3 : 4) tick();
         chk("arb_cpu_ack", 32'(cpu_ack), 32'(exp_cpu[k]));
         chk("arb_dbg_ack", 32'(dbg_ack), 32'(!exp_cpu[k]));
      end
      cpu_req = 1'b0; dbg_req = 1'b0;

      // cpu_req dropped during the address phase
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0020; mem_rdata = 8'h42;
      tick();
      chk("drop_c1_mav", 32'(mem_addr_valid), 1);
      cpu_req = 1'b0;
      tick();
      tick();
      chk("drop_c3_ack", 32'(cpu_ack), 1);
      chk("drop_c3_rdata", 32'(cpu_rdata), 32'h42);
      tick();
      chk("drop_c4_ack", 32'(cpu_ack), 0);
      chk("drop_c4_busy", 32'(busy), 0);
      tick();
      chk("drop_c5_busy", 32'(busy), 0);
      chk("drop_c5_mav", 32'(mem_addr_valid), 0);

      // Reset asserted during a write data phase
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0040; cpu_wdata = 8'h99;
      tick();
      tick();
      chk("rstd_en_before", 32'(mem_en), 1);
      chk("rstd_we_before", 32'(mem_we), 1);
      rst_n = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      #1;
      chk("rstd_en_async", 32'(mem_en), 0);
      chk("rstd_we_async", 32'(mem_we), 0);
      chk("rstd_busy_async", 32'(busy), 0);
      tick();
      chk("rstd_no_ack", 32'(cpu_ack), 0);
      rst_n = 1'b1;
      tick();
      chk("rstd_no_ack_after", 32'(cpu_ack), 0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0000; mem_rdata = 8'hC3;
      tick();
      chk("rstd_fresh_mav", 32'(mem_addr_valid), 1);
      chk("rstd_fresh_addr", 32'(mem_addr), 0);
      tick();
      chk("rstd_fresh_en", 32'(mem_en), 1);
      chk("rstd_fresh_we", 32'(mem_we), 0);
      tick();
      chk("rstd_fresh_ack", 32'(cpu_ack), 1);
      chk("rstd_fresh_rdata", 32'(cpu_rdata), 32'hC3);
      cpu_req = 1'b0;
      tick();

      // CPU request held across ack: back-to-back accesses
      do_reset();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0100; mem_rdata = 8'h5A;
      repeat (3) tick();
      chk("b2b_ack1", 32'(cpu_ack), 1);
      chk("b2b_rdata1", 32'(cpu_rdata), 32'h5A);
      mem_rdata = 8'h3C;
      tick();
      chk("b2b_c4_ack", 32'(cpu_ack), 0);
      chk("b2b_c4_busy", 32'(busy), 0);
      tick();
      chk("b2b_c5_mav", 32'(mem_addr_valid), 1);
      tick();
      chk("b2b_c6_en", 32'(mem_en), 1);
      chk("b2b_c6_ack", 32'(cpu_ack), 0);
      tick();
      chk("b2b_ack2", 32'(cpu_ack), 1);
      chk("b2b_rdata2", 32'(cpu_rdata), 32'h3C);
      chk("b2b_dbg_ack", 32'(dbg_ack), 0);
      cpu_req = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
